// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter
// Round-robin arbiter that multiplexes N_REQ requesters onto a single BRAM port.
// Reads may be multi-beat bursts; read data comes back tagged to its owner
// through a shift register matched to the BRAM read latency.
// Optional build macro ARB_CPU_PRIORITY_EN: requester 0 wins every IDLE
// arbitration in which it is requesting (grant_id still tracks the winner).

module bram_rr_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 32,
   parameter int LEN_W    = 3,
   parameter int BRAM_LAT = 1
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_we,
   input  logic [N_REQ*ADDR_W-1:0]     req_addr,
   input  logic [N_REQ*DATA_W-1:0]     req_wdata,
   input  logic [N_REQ*LEN_W-1:0]      req_len,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        bram_en,
   output logic                        bram_we,
   output logic [ADDR_W-1:0]           bram_addr,
   output logic [DATA_W-1:0]           bram_wdata,
   input  logic [DATA_W-1:0]           bram_rdata,
   output logic                        busy,
   output logic [$clog2(N_REQ)-1:0]    grant_id
);

   localparam int GW = $clog2(N_REQ);
   localparam int BW = LEN_W + 1;

   typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

   // Per-requester views of the flattened request buses.
   logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
   logic [N_REQ-1:0][DATA_W-1:0] wdata_a;
   logic [N_REQ-1:0][LEN_W-1:0]  len_a;

   assign addr_a  = req_addr;
   assign wdata_a = req_wdata;
   assign len_a   = req_len;

   state_e                  state_q, state_d;
   logic [GW-1:0]           grant_id_q, grant_id_d;
   logic [GW-1:0]           win, cand;
   logic                    we_q, we_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [BW-1:0]           beat_q, beat_d;

   logic [N_REQ-1:0]        req_ready_q, req_ready_d;
   logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
   logic                    bram_en_q, bram_en_d;
   logic                    bram_we_q, bram_we_d;
   logic [ADDR_W-1:0]       bram_addr_q, bram_addr_d;
   logic [DATA_W-1:0]       bram_wdata_q, bram_wdata_d;
   logic                    busy_q, busy_d;

   // Response pipeline: stage k holds the read beat issued k cycles ago.
   logic [BRAM_LAT:1]           vld_pipe_q, vld_pipe_d;
   logic [BRAM_LAT:1][GW-1:0]   own_pipe_q, own_pipe_d;

   // Round-robin pick: first requesting index searching upward from grant_id+1.
   // Scanning downward and overwriting leaves the nearest candidate in win.
   always_comb begin
      win  = grant_id_q;
      cand = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         cand = GW'((int'(grant_id_q) + i) % N_REQ);
         if (req_valid[cand]) win = cand;
      end
`ifdef ARB_CPU_PRIORITY_EN
      if (req_valid[0]) win = '0;
`else
`endif
   end

   // FSM next state and registered-output next values.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      we_d         = we_q;
      len_d        = len_q;
      beat_d       = beat_q;
      req_ready_d  = '0;
      bram_en_d    = 1'b0;
      bram_we_d    = 1'b0;
      bram_addr_d  = bram_addr_q;
      bram_wdata_d = bram_wdata_q;
      busy_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               // Beat 0 goes out on the cycle right after the grant edge.
               state_d          = S_BURST;
               grant_id_d       = win;
               we_d             = req_we[win];
               len_d            = len_a[win];
               beat_d           = '0;
               req_ready_d[win] = 1'b1;
               bram_en_d        = 1'b1;
               bram_we_d        = req_we[win];
               bram_addr_d      = addr_a[win];
               busy_d           = 1'b1;
               if (req_we[win]) bram_wdata_d = wdata_a[win];
            end
         end
         S_BURST: begin
            // beat_q is the beat currently on the BRAM port.
            if (we_q || (beat_q == {1'b0, len_q})) begin
               state_d = S_IDLE;
            end else begin
               beat_d                  = beat_q + BW'(1);
               req_ready_d[grant_id_q] = 1'b1;
               bram_en_d               = 1'b1;
               bram_addr_d             = bram_addr_q + ADDR_W'(1);
               busy_d                  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Response pipeline shift and tagged capture of BRAM read data.
   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      own_pipe_d    = own_pipe_q;
      vld_pipe_d[1] = bram_en_q & ~bram_we_q;
      own_pipe_d[1] = grant_id_q;
      for (int k = 2; k <= BRAM_LAT; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         own_pipe_d[k] = own_pipe_q[k-1];
      end
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (vld_pipe_q[BRAM_LAT]) begin
         rsp_valid_d[own_pipe_q[BRAM_LAT]] = 1'b1;
         rsp_data_d                        = bram_rdata;
      end
   end

   // State and output registers; reset drops any in-flight responses.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         grant_id_q   <= GW'(N_REQ - 1);
         we_q         <= 1'b0;
         len_q        <= '0;
         beat_q       <= '0;
         req_ready_q  <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         bram_en_q    <= 1'b0;
         bram_we_q    <= 1'b0;
         bram_addr_q  <= '0;
         bram_wdata_q <= '0;
         busy_q       <= 1'b0;
         vld_pipe_q   <= '0;
         own_pipe_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         we_q         <= we_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         bram_en_q    <= bram_en_d;
         bram_we_q    <= bram_we_d;
         bram_addr_q  <= bram_addr_d;
         bram_wdata_q <= bram_wdata_d;
         busy_q       <= busy_d;
         vld_pipe_q   <= vld_pipe_d;
         own_pipe_q   <= own_pipe_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign bram_en    = bram_en_q;
   assign bram_we    = bram_we_q;
   assign bram_addr  = bram_addr_q;
   assign bram_wdata = bram_wdata_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Parametrised successor to the single-port BRAM access arbiter in the user project.
- Arbitrates N_REQ requesters (CPU Wishbone front-end, DMA read, DMA write, FIFO prefetch, ...) onto one BRAM controller port.
- Uses round-robin fairness and supports multi-beat read bursts.
- Returns read data tagged to the owning requester through a latency-matched response pipeline.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 13, BRAM word-address width.
- DATA_W, 32, data width.
- LEN_W, 3, burst length field width; value = beats-1.
- BRAM_LAT, 1, BRAM read latency in cycles from bram_en to valid bram_rdata (1..4).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request.
- req_we  in  N_REQ  1 = write (single beat), 0 = read burst.
- req_addr  in  N_REQ*ADDR_W  start word address; requester i occupies slice i.
- req_wdata  in  N_REQ*DATA_W  write data.
- req_len  in  N_REQ*LEN_W  read beats-1; ignored for writes.
- req_ready  out  N_REQ  one-hot; pulses once per beat issued for the owner.
- rsp_valid  out  N_REQ  one-hot; read data valid for that requester.
- rsp_data  out  DATA_W  read data, shared by all requesters.
- bram_en  out  1  BRAM access strobe.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data.
- busy  out  1  high while in the BURST state.
- grant_id  out  clog2(N_REQ)  current or last owner.

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0.
  - bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
  - busy=0, grant_id=N_REQ-1, so requester 0 has priority on the first round.
- FSM has two states, IDLE and BURST.
- IDLE:
  - If no req_valid is high, stay in IDLE.
  - Otherwise the winner is the first set req_valid bit searching upward (mod N_REQ) from grant_id+1.
  - On the edge, latch owner, req_we, addr and len; wdata is latched for writes. Set grant_id=owner and go to BURST.
- BURST:
  - One beat is issued per cycle: bram_en=1, bram_we=latched we, bram_addr=base+beat, req_ready[owner]=1.
  - Address wraps modulo 2^ADDR_W (e.g. 0x1FFF+1 -> 0x0000).
  - Beat counter is LEN_W+1 bits wide.
  - After beat len (write: after beat 0) the FSM returns to IDLE. Exactly one IDLE cycle separates bursts.
- Requester handshake:
  - The requester must drop or change req_valid by the cycle after its last req_ready; IDLE re-samples it.
  - req_valid and inputs are ignored in BURST; deassertion does not abort a burst.
- Response pipeline:
  - A BRAM_LAT-deep shift register carries {read_beat, owner}.
  - rsp_data captures bram_rdata, and rsp_valid[owner] pulses exactly BRAM_LAT+1 cycles after the matching bram_en read cycle.
  - Responses return in issue order. Writes produce no rsp_valid.
  - The pipeline drains independently of the FSM, so responses may overlap a new grant.
- Simultaneous requests: round-robin order only; requesters with req_valid low are skipped.
- Reset mid-burst: the FSM is forced to IDLE, the pipeline is cleared, and in-flight responses are discarded (no rsp_valid).

Optional Feature:
- Macro: ARB_CPU_PRIORITY_EN.
- When defined: in IDLE, requester 0 (CPU) wins whenever req_valid[0]=1, overriding round-robin. grant_id still updates.
- When undefined: pure round-robin as above.

Test Plan:
All cases use N_REQ=3, ADDR_W=13, DATA_W=32, LEN_W=3, BRAM_LAT=1 unless stated.
- Reset then idle -> all outputs 0, grant_id=2, no bram_en for 20 cycles.
- Req1 read addr 0x0010 len 3, BRAM model returns addr^0xA5A5 -> bram_addr 0x10..0x13 on 4 consecutive cycles, req_ready[1] x4, rsp_valid[1] x4 starting 2 cycles after the first bram_en, data 0xA5B5..0xA5B6 pattern matches.
- Req0 and req2 both assert single reads at reset -> order 0, 2, 0, 2 with one idle cycle between grants. With ARB_CPU_PRIORITY_EN defined and req0 held high -> req0 is granted every time.
- Req2 write addr 0x0100 data 0xDEADBEEF -> one cycle bram_en=1, bram_we=1, bram_addr=0x100, bram_wdata=0xDEADBEEF; no rsp_valid.
- Read addr 0x1FFE len 3 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Assert wb_rst_i asynchronously during beat 2 of a len=7 burst -> outputs clear immediately; no rsp_valid after reset; the next request is arbitrated normally.
